ka_seq16_ctrl: RTL and testbench
================================

// Module: ka_seq16_ctrl
// PURPOSE
//  Sequencer that computes a 16x16 unsigned product using one shared ka_8x8
//  Karatsuba-tree multiplier over four cycles, one 8x8 partial product per cycle.
//  It latches operands, steers the multiplier inputs and shift-accumulates into a
//  32-bit result. Valid/ready handshakes on both sides.
//  Sits between an operand source (e.g. MAC/filter front end) and its consumer.
// PARAMETERS
//  CNT_W   16   width of done_cnt completed-operation counter (saturating)
// PORTS
//  clk        in   1     sole clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     operand pair valid
//  in_ready   out  1     block can accept operands this cycle
//  a          in   16    multiplicand, unsigned
//  b          in   16    multiplier, unsigned
//  out_valid  out  1     p holds a finished product
//  out_ready  in   1     consumer takes p this cycle
//  p          out  32    product a*b, unsigned
//  busy       out  1     state != IDLE
//  done_cnt   out  CNT_W count of output handshakes, saturates at all-ones
// BEHAVIOUR
//  Reset (async, any state, mid-operation included): state=IDLE, step=0, acc=0,
//   op regs=0, out_valid=0, p=0, busy=0, done_cnt=0; in-flight op is discarded.
//  FSM IDLE -> MUL -> DONE -> IDLE (or DONE -> MUL on back-to-back accept).
//  in_ready = (state==IDLE) | (state==DONE & out_ready); combinational.
//  Accept = in_valid & in_ready: latch a,b into op_a,op_b; acc<=0; step<=0; ->MUL.
//  MUL, one partial product per cycle (step 2-bit):
//   step0: op_a[7:0]*op_b[7:0]   << 0
//   step1: op_a[15:8]*op_b[7:0]  << 8
//   step2: op_a[7:0]*op_b[15:8]  << 8
//   step3: op_a[15:8]*op_b[15:8] << 16
//   acc <= acc + (pp16 zero-extended to 32, shifted); 32-bit add, no overflow possible.
//   after step3 -> DONE. ka_8x8 inputs are muxed by step, combinational, not registered.
//  Latency: accept at edge t -> out_valid=1 after edge t+4; p = acc, stable in DONE.
//  DONE: hold p and out_valid until out_ready. On out_ready: done_cnt++ (saturating);
//   if in_valid same cycle, accept new op (-> MUL, out_valid drops next cycle);
//   else -> IDLE, out_valid drops. Throughput back-to-back: 1 result per 5 cycles.
//  in_valid while MUL: ignored (in_ready=0); source must hold a,b until accepted.
//  out_ready while not DONE: ignored. a,b changes after accept do not affect result.
//  p and out_valid are registered; no output glitches on handshake.
// STRUCTURE
//  ka_ctrl_pkg: typedef enum {ST_IDLE, ST_MUL, ST_DONE} ka_state_t; localparam
//   PP_SHIFT[0:3] = {0,8,8,16}; operand-half select table.
//  One sub-module instance: ka_8x8 (shared multiplier). Controller FSM, operand
//   mux and accumulator live in this module.
// TESTING
//  Reset, idle: in_ready=1, out_valid=0, p=0, done_cnt=0, busy=0.
//  a=0x1234,b=0x5678, out_ready=1 -> out_valid 4 cycles after accept, p=0x06260060.
//  a=0xFFFF,b=0xFFFF -> p=0xFFFE0001; a=0x0000,b=0xABCD -> p=0; a=0x0100,b=0x0100 -> p=0x00010000.
//  out_ready=0 for 10 cycles in DONE -> p, out_valid stable, in_ready=0; then release -> done_cnt=1.
//  in_valid held high, out_ready=1, 3 ops 0x0003*0x0005,0x00FF*0x0101,0x8000*0x0002 ->
//   p=0x0F,0xFFFF,0x10000 at 5-cycle spacing; done_cnt=3.
//  Assert rst at step2 of 0xFFFF*0xFFFF -> all outputs reset value at once; next op 7*9 -> p=0x3F.

Source files
------------

// File: rtl/ka_seq16_ctrl_pkg.sv
// Shared types and constants for the 16x16 sequenced Karatsuba multiplier.
// Step tables map each of the four MUL cycles to operand halves and result shift.
package ka_seq16_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} ka_state_t;

  localparam int OP_W   = 16;
  localparam int HALF_W = 8;
  localparam int P_W    = 32;

  // Indexed by step: bit/entry i belongs to step i.
  localparam logic [3:0][4:0] PP_SHIFT = {5'd16, 5'd8, 5'd8, 5'd0};
  localparam logic [3:0]      A_HI_SEL = 4'b1010;
  localparam logic [3:0]      B_HI_SEL = 4'b1100;

  function automatic logic [HALF_W-1:0] half_sel(input logic [OP_W-1:0] v, input logic hi);
    return hi ? v[OP_W-1:HALF_W] : v[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/ka_seq16_ctrl_if.sv
// Operand/result handshake bundle between the source/consumer and the sequencer.
interface ka_seq16_ctrl_if;
  import ka_seq16_ctrl_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [P_W-1:0]  p;

  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, p);
endinterface

// File: rtl/ka_seq16_ctrl_ka_8x8.sv
// Combinational 8x8 unsigned multiplier, one Karatsuba level over 4-bit halves:
// three 4/5-bit products replace four 4x4 ones.
module ka_8x8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [3:0] ah, al, bh, bl;
  logic [4:0] as, bs;
  logic [7:0] z0, z2;
  logic [9:0] zm, z1;

  assign ah = a_i[7:4];
  assign al = a_i[3:0];
  assign bh = b_i[7:4];
  assign bl = b_i[3:0];

  assign as = {1'b0, ah} + {1'b0, al};
  assign bs = {1'b0, bh} + {1'b0, bl};

  assign z0 = 8'(al) * 8'(bl);
  assign z2 = 8'(ah) * 8'(bh);
  assign zm = 10'(as) * 10'(bs);
  // Cross term ah*bl + al*bh, bounded by 450 so 10 bits never wrap.
  assign z1 = zm - 10'(z0) - 10'(z2);

  assign p_o = {z2, z0} + ({6'b0, z1} << 4);
endmodule

// File: rtl/ka_seq16_ctrl.sv
// 16x16 unsigned multiply sequenced over four cycles on one shared ka_8x8,
// shift-accumulating partial products into a 32-bit result.
module ka_seq16_ctrl
  import ka_seq16_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  ka_seq16_ctrl_if.slave   bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt_o
);
  ka_state_t        state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [P_W-1:0]   p_q, p_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic [HALF_W-1:0] mul_a, mul_b;
  logic [15:0]       pp;
  logic [P_W-1:0]    pp_sh, acc_sum;
  logic              in_ready;

  assign mul_a = half_sel(op_a_q, A_HI_SEL[step_q]);
  assign mul_b = half_sel(op_b_q, B_HI_SEL[step_q]);

  ka_8x8 u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (pp)
  );

  assign pp_sh   = {16'b0, pp} << PP_SHIFT[step_q];
  assign acc_sum = acc_q + pp_sh;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    done_cnt_d  = done_cnt_q;

    case (state_q)
      ST_MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d     = ST_DONE;
          p_d         = acc_sum;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (done_cnt_q != '1) done_cnt_d = done_cnt_q + CNT_W'(1);
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance shares one path for IDLE and the back-to-back DONE case.
    if (bus.in_valid && in_ready) begin
      op_a_d  = bus.a;
      op_b_d  = bus.b;
      acc_d   = '0;
      step_d  = 2'd0;
      state_d = ST_MUL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_cnt_o    = done_cnt_q;
endmodule

// File: tb/tb_ka_seq16_ctrl.sv
// Bench for ka_seq16_ctrl: transaction-level model checked every cycle plus
// directed vectors with literal products, latency, spacing and reset checks.
module tb_ka_seq16_ctrl;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic [CW-1:0] done_cnt;

  ka_seq16_ctrl_if bus();

  ka_seq16_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_o     (busy),
    .done_cnt_o (done_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_rem = -1 idle, 4..1 cycles of work left, 0 result waiting.
  int          m_rem = -1;
  logic [15:0] m_a = '0, m_b = '0;
  logic [31:0] m_p = '0;
  int          m_cnt = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    logic acc;
    if (rst) begin
      m_rem = -1; m_p = '0; m_cnt = 0;
    end
    exp_rdy = (m_rem == -1) || (m_rem == 0 && bus.out_ready);
    chk("m_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("m_busy", 32'(busy), 32'(m_rem != -1));
    chk("m_out_valid", 32'(bus.out_valid), 32'(m_rem == 0));
    chk("m_done_cnt", 32'(done_cnt), m_cnt);
    if (m_rem == 0) chk("m_p", bus.p, m_p);
    if (!rst) begin
      acc = bus.in_valid && exp_rdy;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_p = {16'b0, m_a} * {16'b0, m_b};
      end else if (m_rem == 0 && bus.out_ready) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_rem = -1;
      end
      if (acc) begin
        m_rem = 4; m_a = bus.a; m_b = bus.b;
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (bus.in_ready) return;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_p"}, bus.p, 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int hold);
    int n, lat;
    bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_ready(n);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, 32'd4);
    chk("product", bus.p, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_p", bus.p, exp);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [15:0] ba [3] = '{16'h0003, 16'h00FF, 16'h8000};
  logic [15:0] bb [3] = '{16'h0005, 16'h0101, 16'h0002};
  logic [31:0] be [3] = '{32'h0000000F, 32'h0000FFFF, 32'h00010000};

  initial begin
    int n, lat;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst_held");
    rst = 1'b0;
    @(posedge clk); #1 check_reset_vals("idle");

    run_op(16'h1234, 16'h5678, 32'h06260060, 10);
    chk("cnt_after_hold", 32'(done_cnt), 32'd1);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    run_op(16'h0000, 16'hABCD, 32'h00000000, 0);
    chk("cnt_three", 32'(done_cnt), 32'd3);
    run_op(16'h0100, 16'h0100, 32'h00010000, 0);
    chk("cnt_saturated", 32'(done_cnt), 32'd3);

    // Back-to-back with in_valid and out_ready held high.
    do_reset();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = ba[i]; bus.b = bb[i];
      wait_ready(n);
      if (i > 0) begin
        chk("b2b_gap", n, 32'd5);
        chk("b2b_p", bus.p, be[i-1]);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_last_p", bus.p, be[2]);
    @(posedge clk); #1;
    chk("b2b_cnt", 32'(done_cnt), 32'd3);
    bus.out_ready = 1'b0;

    // Reset in the middle of an operation, at step 2.
    do_reset();
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.in_valid = 1'b1;
    wait_ready(n);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 check_reset_vals("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_op(16'h0007, 16'h0009, 32'h0000003F, 0);
    chk("post_rst_cnt", 32'(done_cnt), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
